// File: rtl/mem_port_arbiter.sv
// Arbitrates IF, LD and ST requesters onto the shared byte-serial RAM sequencer, one transaction
// in flight. Define MEM_ARB_STARVE_GUARD_EN to force an IF grant after STARVE_LIMIT lost rounds.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned UART_GAP = 2
`ifdef MEM_ARB_STARVE_GUARD_EN
    ,
    parameter int unsigned STARVE_LIMIT = 4
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              uart_full,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [2:0]        ld_size,
    output logic              ld_done,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [2:0]        st_size,
    output logic              st_done,
    input  logic              sb_empty,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_valid,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_size,
    input  logic              mem_ready,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned GAP_W = $clog2(UART_GAP + 2);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDrop} state_e;
    typedef enum logic [1:0] {SrcIf, SrcLd, SrcSt} src_e;

    state_e            state_q, state_d;
    src_e              src_q, src_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        size_q, size_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [2:0]        done_q, done_d;  // {st, ld, if}
    logic [GAP_W-1:0]  gap_q, gap_d;

    logic st_io, ld_io, st_elig, ld_elig, arb_en, force_if, flush_hit, grant;
    src_e grant_src;

    assign st_io     = (st_addr[17:16] == 2'b11);
    assign ld_io     = (ld_addr[17:16] == 2'b11);
    assign st_elig   = st_req && (!st_io || (!uart_full && (gap_q == '0)));
    assign ld_elig   = ld_req && (!ld_io || sb_empty);
    // The cycle a done pulse is visible the finishing requester still holds its request.
    assign arb_en    = (state_q == StIdle) && (done_q == 3'b000);
    assign flush_hit = flush && (src_q != SrcSt);

    always_comb begin
        grant     = 1'b0;
        grant_src = SrcIf;
        if (arb_en) begin
            if (force_if) begin
                grant     = 1'b1;
                grant_src = SrcIf;
            end else if (st_elig) begin
                grant     = 1'b1;
                grant_src = SrcSt;
            end else if (ld_elig) begin
                grant     = 1'b1;
                grant_src = SrcLd;
            end else if (if_req) begin
                grant     = 1'b1;
                grant_src = SrcIf;
            end
        end
    end

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 2);

    logic [STV_W-1:0] starve_q, starve_d;

    assign force_if = if_req && (starve_q == STV_W'(STARVE_LIMIT));

    always_comb begin
        starve_d = starve_q;
        if (grant) begin
            if (grant_src == SrcIf) begin
                starve_d = '0;
            end else if (if_req && (starve_q != STV_W'(STARVE_LIMIT))) begin
                starve_d = starve_q + STV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else if (rdy) begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        write_d = write_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = 3'b000;
        gap_d   = (gap_q != '0) ? gap_q - GAP_W'(1) : gap_q;
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d = StIssue;
                    src_d   = grant_src;
                    unique case (grant_src)
                        SrcSt: begin
                            write_d = 1'b1;
                            addr_d  = st_addr;
                            size_d  = st_size;
                            wdata_d = st_data;
                        end
                        SrcLd: begin
                            write_d = 1'b0;
                            addr_d  = ld_addr;
                            size_d  = ld_size;
                            wdata_d = '0;
                        end
                        default: begin
                            write_d = 1'b0;
                            addr_d  = if_addr;
                            size_d  = 3'd4;
                            wdata_d = '0;
                        end
                    endcase
                end
            end
            StIssue: begin
                // An accepted request must still be drained even if cancelled.
                if (flush_hit) begin
                    state_d = mem_ready ? StDrop : StIdle;
                end else if (mem_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (mem_done) begin
                    state_d = StIdle;
                    if (!flush_hit) begin
                        unique case (src_q)
                            SrcSt:   done_d = 3'b100;
                            SrcLd:   done_d = 3'b010;
                            default: done_d = 3'b001;
                        endcase
                        if (!write_q) begin
                            rdata_d = mem_rdata;
                        end
                        if (write_q && (addr_q[17:16] == 2'b11)) begin
                            gap_d = GAP_W'(UART_GAP);
                        end
                    end
                end else if (flush_hit) begin
                    state_d = StDrop;
                end
            end
            StDrop: begin
                if (mem_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            src_q   <= SrcIf;
            write_q <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= '0;
            gap_q   <= '0;
        end else if (rdy) begin
            state_q <= state_d;
            src_q   <= src_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            gap_q   <= gap_d;
        end
    end

    assign mem_valid = (state_q == StIssue);
    assign mem_write = write_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_size  = size_q;
    assign rdata     = rdata_q;
    assign if_done   = done_q[0];
    assign ld_done   = done_q[1];
    assign st_done   = done_q[2];

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests, a simple sequencer model, and a
// monitor that checks every issued request and every done pulse against queued expectations.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, uart_full, sb_empty;
    logic        if_req, ld_req, st_req;
    logic [31:0] if_addr, ld_addr, st_addr, st_data;
    logic [2:0]  ld_size, st_size;
    logic        if_done, ld_done, st_done;
    logic [31:0] rdata;
    logic        mem_valid, mem_write, mem_ready, mem_done;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_size;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .UART_GAP(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .flush    (flush),
        .uart_full(uart_full),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_done  (if_done),
        .ld_req   (ld_req),
        .ld_addr  (ld_addr),
        .ld_size  (ld_size),
        .ld_done  (ld_done),
        .st_req   (st_req),
        .st_addr  (st_addr),
        .st_data  (st_data),
        .st_size  (st_size),
        .st_done  (st_done),
        .sb_empty (sb_empty),
        .rdata    (rdata),
        .mem_valid(mem_valid),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_size (mem_size),
        .mem_ready(mem_ready),
        .mem_done (mem_done),
        .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        int          gap_lo;
        int          gap_hi;
    } iss_t;

    typedef struct {
        logic [2:0]  src;
        logic [31:0] rdata;
    } dn_t;

    iss_t iss_q[$];
    dn_t  dn_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_issue(input logic w, input logic [31:0] a, input logic [2:0] s,
                             input logic [31:0] wd, input int lo, input int hi);
        iss_t e;
        e.write  = w;
        e.addr   = a;
        e.size   = s;
        e.wdata  = wd;
        e.gap_lo = lo;
        e.gap_hi = hi;
        iss_q.push_back(e);
    endtask

    task automatic exp_done(input logic [2:0] src, input logic [31:0] rd);
        dn_t d;
        d.src   = src;
        d.rdata = rd;
        dn_q.push_back(d);
    endtask

    // Monitor: pops expectations whenever the DUT presents a request or a done pulse.
    int   cyc = 0;
    int   last_done = 0;
    logic prev_valid = 1'b0;
    iss_t mon_e;
    dn_t  mon_d;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (mem_valid && !prev_valid) begin
                if (iss_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_issue: got addr 0x%0h expected no request", mem_addr);
                end else begin
                    mon_e = iss_q.pop_front();
                    chk("issue_write", {63'd0, mem_write}, {63'd0, mon_e.write});
                    chk("issue_addr", {32'd0, mem_addr}, {32'd0, mon_e.addr});
                    chk("issue_size", {61'd0, mem_size}, {61'd0, mon_e.size});
                    if (mon_e.write) chk("issue_wdata", {32'd0, mem_wdata}, {32'd0, mon_e.wdata});
                    checks++;
                    if ((cyc - last_done) < mon_e.gap_lo || (cyc - last_done) > mon_e.gap_hi) begin
                        errors++;
                        $display("FAIL issue_gap: got %0d cycles expected %0d..%0d",
                                 cyc - last_done, mon_e.gap_lo, mon_e.gap_hi);
                    end
                end
            end
            if (if_done || ld_done || st_done) begin
                if (dn_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got src %b expected none",
                             {st_done, ld_done, if_done});
                end else begin
                    mon_d = dn_q.pop_front();
                    chk("done_src", {61'd0, st_done, ld_done, if_done}, {61'd0, mon_d.src});
                    chk("done_rdata", {32'd0, rdata}, {32'd0, mon_d.rdata});
                end
                last_done = cyc;
            end
        end
        prev_valid = mem_valid;
    end

    // Sequencer model and requester release, all inputs driven on the falling edge.
    int          ready_lat = 0;
    int          done_lat = 2;
    int          seq_wait = 0;
    int          seq_cnt = 0;
    logic        seq_busy = 1'b0;
    logic [31:0] seq_rd = '0;
    logic [2:0]  seen = '0;

    function automatic logic [31:0] seq_data(input logic [31:0] a);
        return (a == 32'h100) ? 32'h13 : (a ^ 32'h5A5A_0000);
    endfunction

    task automatic step();
        @(negedge clk);
        seen = {st_done, ld_done, if_done};
        if (if_done) if_req = 1'b0;
        if (ld_done) ld_req = 1'b0;
        if (st_done) st_req = 1'b0;
        mem_ready = 1'b0;
        mem_done  = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        if (rdy && !rst) begin
            if (seq_busy) begin
                if (seq_cnt == 0) begin
                    mem_done  = 1'b1;
                    mem_rdata = seq_rd;
                    seq_busy  = 1'b0;
                end else begin
                    seq_cnt--;
                end
            end else if (mem_valid) begin
                if (seq_wait >= ready_lat) begin
                    mem_ready = 1'b1;
                    seq_busy  = 1'b1;
                    seq_cnt   = done_lat;
                    seq_rd    = seq_data(mem_addr);
                    seq_wait  = 0;
                end else begin
                    seq_wait++;
                end
            end else begin
                seq_wait = 0;
            end
        end
    endtask

    task automatic wait_done(input int idx, input string name);
        for (int i = 0; i < 80; i++) begin
            step();
            if (seen[idx]) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: got no done expected done within 80 cycles", name);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 40; i++) begin
            step();
            if (mem_valid) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: got no mem_valid expected mem_valid within 40 cycles", name);
    endtask

    task automatic wait_seq(input logic want_done, input string name);
        for (int i = 0; i < 40; i++) begin
            step();
            if (want_done ? mem_done : mem_ready) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: got no handshake expected one within 40 cycles", name);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; uart_full = 1'b0; sb_empty = 1'b1;
        if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
        if_addr = '0; ld_addr = '0; st_addr = '0; st_data = '0; ld_size = '0; st_size = '0;
        mem_ready = 1'b0; mem_done = 1'b0; mem_rdata = '0;
        repeat (3) step();
        chk("rst_valid", {63'd0, mem_valid}, 64'd0);
        chk("rst_write", {63'd0, mem_write}, 64'd0);
        chk("rst_addr", {32'd0, mem_addr}, 64'd0);
        chk("rst_wdata", {32'd0, mem_wdata}, 64'd0);
        chk("rst_size", {61'd0, mem_size}, 64'd0);
        chk("rst_rdata", {32'd0, rdata}, 64'd0);
        chk("rst_dones", {61'd0, st_done, ld_done, if_done}, 64'd0);
        rst = 1'b0;
        step();

        // Lone fetch
        exp_issue(1'b0, 32'h100, 3'd4, 32'h0, 0, 100000);
        exp_done(3'b001, 32'h0000_0013);
        if_addr = 32'h100; if_req = 1'b1;
        wait_done(0, "t1_if");

        // All three at once: ST, LD, IF, each issue two cycles after the previous done
        exp_issue(1'b1, 32'h1000, 3'd4, 32'hCAFE_F00D, 0, 100000);
        exp_issue(1'b0, 32'h2000, 3'd4, 32'h0, 2, 2);
        exp_issue(1'b0, 32'h104, 3'd4, 32'h0, 2, 2);
        exp_done(3'b100, 32'h0000_0013);
        exp_done(3'b010, 32'h5A5A_2000);
        exp_done(3'b001, 32'h5A5A_0104);
        st_addr = 32'h1000; st_data = 32'hCAFE_F00D; st_size = 3'd4; st_req = 1'b1;
        ld_addr = 32'h2000; ld_size = 3'd4; ld_req = 1'b1;
        if_addr = 32'h104; if_req = 1'b1;
        wait_done(0, "t2_if");

        // IO load waits for an empty write buffer
        exp_issue(1'b1, 32'h1000, 3'd1, 32'h1122_3344, 0, 100000);
        exp_done(3'b100, 32'h5A5A_0104);
        sb_empty = 1'b0;
        st_addr = 32'h1000; st_data = 32'h1122_3344; st_size = 3'd1; st_req = 1'b1;
        ld_addr = 32'h30000; ld_size = 3'd2; ld_req = 1'b1;
        wait_done(2, "t3_st");
        for (int i = 0; i < 4; i++) begin
            step();
            chk("io_ld_held", {63'd0, mem_valid}, 64'd0);
        end
        exp_issue(1'b0, 32'h30000, 3'd2, 32'h0, 0, 100000);
        exp_done(3'b010, 32'h5A59_0000);
        sb_empty = 1'b1;
        wait_done(1, "t3_ld");

        // IO stores: UART gap, then back-pressure
        exp_issue(1'b1, 32'h30000, 3'd1, 32'h41, 0, 100000);
        exp_done(3'b100, 32'h5A59_0000);
        st_addr = 32'h30000; st_data = 32'h41; st_size = 3'd1; st_req = 1'b1;
        wait_done(2, "t4_st1");
        exp_issue(1'b1, 32'h30000, 3'd1, 32'h42, 2, 100000);
        exp_done(3'b100, 32'h5A59_0000);
        st_data = 32'h42; st_req = 1'b1;
        wait_done(2, "t4_st2");
        uart_full = 1'b1; st_data = 32'h43; st_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("uart_full_hold", {63'd0, mem_valid}, 64'd0);
        end
        exp_issue(1'b1, 32'h30000, 3'd1, 32'h43, 2, 100000);
        exp_done(3'b100, 32'h5A59_0000);
        uart_full = 1'b0;
        wait_done(2, "t4_st3");

        // Flush while the load is in flight; pending fetch follows
        done_lat = 3;
        exp_issue(1'b0, 32'h2000, 3'd4, 32'h0, 0, 100000);
        exp_issue(1'b0, 32'h200, 3'd4, 32'h0, 0, 100000);
        exp_done(3'b001, 32'h5A5A_0200);
        ld_addr = 32'h2000; ld_size = 3'd4; ld_req = 1'b1;
        if_addr = 32'h200; if_req = 1'b1;
        wait_seq(1'b0, "t5_ready");
        step();
        flush = 1'b1; ld_req = 1'b0;
        step();
        flush = 1'b0;
        wait_seq(1'b1, "t5_mem_done");
        step();
        chk("flush_rdata_kept", {32'd0, rdata}, {32'd0, 32'h5A59_0000});
        wait_done(0, "t5_if");

        // rdy low freezes an outstanding request
        done_lat = 2; ready_lat = 3;
        exp_issue(1'b0, 32'h300, 3'd4, 32'h0, 0, 100000);
        exp_done(3'b001, 32'h5A5A_0300);
        if_addr = 32'h300; if_req = 1'b1;
        wait_valid("t6");
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rdy_hold_valid", {63'd0, mem_valid}, 64'd1);
            chk("rdy_hold_addr", {32'd0, mem_addr}, {32'd0, 32'h300});
        end
        rdy = 1'b1;
        wait_done(0, "t6_if");

        // Flush before the sequencer accepts: request withdrawn
        ready_lat = 5;
        exp_issue(1'b0, 32'h2000, 3'd4, 32'h0, 0, 100000);
        ld_addr = 32'h2000; ld_req = 1'b1;
        wait_valid("t7");
        flush = 1'b1; ld_req = 1'b0;
        step();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("issue_flush_drop", {63'd0, mem_valid}, 64'd0);
            step();
        end
        ready_lat = 0;

        repeat (3) step();
        chk("iss_q_empty", 64'(iss_q.size()), 64'd0);
        chk("dn_q_empty", 64'(dn_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
